// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the CPU sequencer and its instruction memory, decoder and data memory.
// master is the sequencer side; slave is the memory/decoder side.
interface cpu_sequencer_if #(
   parameter int unsigned PC_W = 8
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;
   logic            imem_ack;
   logic [15:0]     ir;
   logic            ld;
   logic            mw;
   logic            md;
   logic            bs;
   logic            halt;
   logic [5:0]      off;
   logic            zero;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_ack;
   logic            reg_we;

   modport master (
      output imem_req, imem_addr, ir, dmem_req, dmem_we, reg_we,
      input  imem_rdata, imem_ack, ld, mw, md, bs, halt, off, zero, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, ir, dmem_req, dmem_we, reg_we,
      output imem_rdata, imem_ack, ld, mw, md, bs, halt, off, zero, dmem_ack
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit single-bus CPU: owns PC/IR, fetches,
// steps each instruction through decode/execute/mem/writeback, resolves branches, halts.
module cpu_sequencer #(
   parameter int unsigned PC_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   cpu_sequencer_if.master       bus,
   output logic                  halted,
   output logic [2:0]            state,
   output logic [15:0]           retired
);

   typedef enum logic [2:0] {
      StFetch   = 3'd0,
      StDecode  = 3'd1,
      StExecute = 3'd2,
      StMem     = 3'd3,
      StWb      = 3'd4,
      StHlt     = 3'd5
   } state_e;

   state_e          state_q;
   logic [PC_W-1:0] pc_q;
   logic [15:0]     ir_q;
   logic [15:0]     retired_q;
   logic            req_hold_q;
   logic [PC_W-1:0] off_ext;

   assign off_ext = {{(PC_W-6){bus.off[5]}}, bus.off};

   // Once a fetch request has been seen at a clock edge it stays up until ACK, even if RUN drops.
   assign bus.imem_req  = (state_q == StFetch) && (run || req_hold_q);
   assign bus.imem_addr = pc_q;
   assign bus.ir        = ir_q;
   assign bus.dmem_req  = (state_q == StMem);
   assign bus.dmem_we   = (state_q == StMem) && bus.mw;
   assign bus.reg_we    = (state_q == StWb);
   assign halted        = (state_q == StHlt);
   assign state         = state_q;
   assign retired       = retired_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StFetch;
         pc_q       <= '0;
         ir_q       <= '0;
         retired_q  <= '0;
         req_hold_q <= 1'b0;
      end else begin
         req_hold_q <= 1'b0;
         case (state_q)
            StFetch: begin
               if (bus.imem_req && bus.imem_ack) begin
                  ir_q    <= bus.imem_rdata;
                  pc_q    <= pc_q + PC_W'(1);
                  state_q <= StDecode;
               end else begin
                  req_hold_q <= bus.imem_req;
               end
            end
            StDecode: begin
               if (bus.halt) begin
                  state_q   <= StHlt;
                  retired_q <= retired_q + 16'd1;
               end else begin
                  state_q <= StExecute;
               end
            end
            StExecute: begin
               // pc_q already points one past this instruction, so the offset is PC-relative+1.
               if (bus.bs) begin
                  if (bus.zero) pc_q <= pc_q + off_ext;
                  state_q   <= StFetch;
                  retired_q <= retired_q + 16'd1;
               end else if (bus.mw || bus.md) begin
                  state_q <= StMem;
               end else if (bus.ld) begin
                  state_q <= StWb;
               end else begin
                  state_q   <= StFetch;
                  retired_q <= retired_q + 16'd1;
               end
            end
            StMem: begin
               if (bus.dmem_ack) begin
                  if (bus.md) begin
                     state_q <= StWb;
                  end else begin
                     state_q   <= StFetch;
                     retired_q <= retired_q + 16'd1;
                  end
               end
            end
            StWb: begin
               state_q   <= StFetch;
               retired_q <= retired_q + 16'd1;
            end
            StHlt:   state_q <= StHlt;
            default: state_q <= StFetch;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: ALU/load/store/NOP/branch/wrap/halt/reset-mid-MEM.
// Instruction word doubles as decoder output: [0]=LD [1]=MW [2]=MD [3]=BS [4]=HALT [10:5]=OFF.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        halted;
   logic [2:0]  state;
   logic [15:0] retired;
   logic        imem_ack_en;
   logic        spurious;
   logic        zero_r;
   logic        dmem_ack_r;
   logic [15:0] imem [256];
   int          vectors = 0;
   int          miscompares = 0;

   cpu_sequencer_if #(.PC_W(8)) bus ();

   cpu_sequencer #(.PC_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .bus     (bus),
      .halted  (halted),
      .state   (state),
      .retired (retired)
   );

   always #5 clk = ~clk;

   assign bus.imem_rdata = imem[bus.imem_addr];
   assign bus.imem_ack   = (imem_ack_en & bus.imem_req) | spurious;
   assign bus.ld         = bus.ir[0];
   assign bus.mw         = bus.ir[1];
   assign bus.md         = bus.ir[2];
   assign bus.bs         = bus.ir[3];
   assign bus.halt       = bus.ir[4];
   assign bus.off        = bus.ir[10:5];
   assign bus.zero       = zero_r;
   assign bus.dmem_ack   = dmem_ack_r;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; imem_ack_en = 1'b1; spurious = 1'b0;
      zero_r = 1'b0; dmem_ack_r = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
      imem[0] = 16'h0001;   // ALU op
      imem[1] = 16'h0005;   // load
      imem[2] = 16'h0002;   // store
      imem[5] = 16'h0788;   // branch, off -4
      nxt;
      chk("rst_state", state, 0);
      chk("rst_pc", bus.imem_addr, 0);
      chk("rst_ir", bus.ir, 0);
      chk("rst_retired", retired, 0);
      chk("rst_outs", {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.reg_we, halted}, 0);

      // ALU op: F D E W
      rst = 1'b0; run = 1'b1;
      #1;
      chk("alu_f_state", state, 0);
      chk("alu_f_req", bus.imem_req, 1);
      nxt;
      chk("alu_d_state", state, 1);
      chk("alu_d_ir", bus.ir, 16'h0001);
      chk("alu_d_regwe", bus.reg_we, 0);
      nxt;
      chk("alu_e_state", state, 2);
      chk("alu_e_regwe", bus.reg_we, 0);
      nxt;
      chk("alu_w_state", state, 4);
      chk("alu_w_regwe", bus.reg_we, 1);
      nxt;
      chk("alu_done_state", state, 0);
      chk("alu_done_regwe", bus.reg_we, 0);
      chk("alu_done_pc", bus.imem_addr, 1);
      chk("alu_done_ret", retired, 1);

      // Load with DMEM_ACK on the 4th MEM cycle
      nxt;
      chk("ld_d_ir", bus.ir, 16'h0005);
      nxt;
      chk("ld_e_state", state, 2);
      nxt;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dmem_ack_r = 1'b1;
         chk("ld_mem_state", state, 3);
         chk("ld_mem_req_we", {bus.dmem_req, bus.dmem_we, bus.reg_we}, 3'b100);
         nxt;
      end
      dmem_ack_r = 1'b0;
      chk("ld_wb_state", state, 4);
      chk("ld_wb_regwe", {bus.reg_we, bus.dmem_req}, 2'b10);
      nxt;
      chk("ld_done_state", state, 0);
      chk("ld_done_ret", retired, 2);
      chk("ld_done_pc", bus.imem_addr, 2);

      // Store, zero-wait DMEM
      nxt;
      chk("st_d_regwe", bus.reg_we, 0);
      nxt;
      chk("st_e_regwe", bus.reg_we, 0);
      nxt;
      dmem_ack_r = 1'b1;
      chk("st_mem_state", state, 3);
      chk("st_mem_req_we", {bus.dmem_req, bus.dmem_we, bus.reg_we}, 3'b110);
      nxt;
      dmem_ack_r = 1'b0;
      chk("st_done_state", state, 0);
      chk("st_done_regwe", bus.reg_we, 0);
      chk("st_done_ret", retired, 3);

      // NOPs at 3 and 4
      for (int i = 0; i < 6; i++) nxt;
      chk("nop_pc", bus.imem_addr, 5);
      chk("nop_ret", retired, 5);

      // Branch at 5, taken: 6 - 4 = 2
      zero_r = 1'b1;
      nxt; nxt; nxt;
      zero_r = 1'b0;
      chk("br_taken_pc", bus.imem_addr, 8'h02);
      chk("br_taken_ret", retired, 6);

      // Store, NOP, NOP again, then branch at 5 not taken; RUN dropped during EXECUTE
      dmem_ack_r = 1'b1;
      for (int i = 0; i < 10; i++) nxt;
      chk("loop_pc", bus.imem_addr, 5);
      chk("loop_ret", retired, 9);
      nxt; nxt;
      run = 1'b0;
      nxt;
      dmem_ack_r = 1'b0;
      chk("br_nt_pc", bus.imem_addr, 8'h06);
      chk("br_nt_ret", retired, 10);
      chk("idle_req", bus.imem_req, 0);
      nxt; nxt;
      chk("idle_state", state, 0);
      chk("idle_pc", bus.imem_addr, 8'h06);

      // Sticky request: raised with RUN, held after RUN drops until ACK
      imem_ack_en = 1'b0; run = 1'b1;
      nxt;
      run = 1'b0;
      #1;
      chk("sticky_req", bus.imem_req, 1);
      imem_ack_en = 1'b1;
      nxt;
      chk("sticky_state", state, 1);
      chk("sticky_pc", bus.imem_addr, 8'h07);

      // Wrap and HALT program after reset
      rst = 1'b1;
      imem[0] = 16'h07C8;   // branch, off -2 -> 0xFF
      imem[1] = 16'h0000;
      imem[2] = 16'h0000;
      imem[3] = 16'h0010;   // HALT
      imem[255] = 16'h0028; // branch, off +1 -> wraps to 0x01
      #1;
      chk("rst2_state", state, 0);
      chk("rst2_pc", bus.imem_addr, 0);
      nxt;
      rst = 1'b0; run = 1'b1; zero_r = 1'b1;
      nxt; nxt; nxt;
      chk("wrap_ff_pc", bus.imem_addr, 8'hFF);
      nxt; nxt; nxt;
      chk("wrap_01_pc", bus.imem_addr, 8'h01);
      chk("wrap_ret", retired, 2);
      zero_r = 1'b0;
      for (int i = 0; i < 6; i++) nxt;
      chk("pre_halt_pc", bus.imem_addr, 8'h03);
      nxt;
      chk("halt_d_ir", bus.ir, 16'h0010);
      nxt;
      chk("halt_state", state, 5);
      chk("halt_flag", halted, 1);
      chk("halt_ret", retired, 5);
      spurious = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("halt_no_req", bus.imem_req, 0);
         nxt;
      end
      chk("halt_hold_state", state, 5);
      chk("halt_hold_ret", retired, 5);
      chk("halt_hold_pc", bus.imem_addr, 8'h04);

      // Reset mid-MEM with DMEM_REQ high, then a late ACK
      spurious = 1'b0;
      rst = 1'b1;
      imem[0] = 16'h0002;
      #1;
      chk("rst3_halted", halted, 0);
      nxt;
      rst = 1'b0;
      nxt; nxt; nxt;
      chk("rm_mem_state", state, 3);
      chk("rm_mem_req", bus.dmem_req, 1);
      run = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("rm_req_drop", {bus.dmem_req, bus.dmem_we}, 2'b00);
      chk("rm_state", state, 0);
      nxt;
      rst = 1'b0;
      dmem_ack_r = 1'b1;
      nxt; nxt;
      dmem_ack_r = 1'b0;
      chk("rm_after_state", state, 0);
      chk("rm_after_pc", bus.imem_addr, 0);
      chk("rm_after_ret", retired, 0);
      chk("rm_after_outs", {bus.dmem_req, bus.reg_we, bus.imem_req}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
